// File: rtl/rc_filter_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : rc_filter_scheduler
// Brief    : Time-multiplexed first-order RC (high/low-pass) filter for NUM_CH
//            channels sharing one multiplier. Optional build macro:
//            RC_FILTER_SCHEDULER_DITHER_EN (LFSR dither on high-pass last_in).
// Revision : 1.0 - initial release
// =============================================================================
module rc_filter_scheduler #(
  parameter int          NUM_CH        = 4,
  parameter logic [15:0] ALPHA_DEFAULT = 16'hF000,
  localparam int         CHW           = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 audio_clk_en,
  input  logic [NUM_CH*16-1:0] in_data,
  output logic [NUM_CH*16-1:0] out_data,
  input  logic                 cfg_we,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic [15:0]          cfg_alpha,
  input  logic                 cfg_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [1:0]     ST_IDLE = 2'd0;
  localparam logic [1:0]     ST_MUL  = 2'd1;
  localparam logic [1:0]     ST_WB   = 2'd2;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

  logic [1:0]          state_q, state_d;
  logic [CHW-1:0]      ch_q, ch_d;

  logic signed [15:0]  out_q       [NUM_CH];
  logic signed [15:0]  out_d       [NUM_CH];
  logic signed [15:0]  last_in_q   [NUM_CH];
  logic signed [15:0]  last_in_d   [NUM_CH];
  logic signed [15:0]  snap_q      [NUM_CH];
  logic signed [15:0]  snap_d      [NUM_CH];
  logic [15:0]         alpha_act_q [NUM_CH];
  logic [15:0]         alpha_act_d [NUM_CH];
  logic [15:0]         alpha_sh_q  [NUM_CH];
  logic [15:0]         alpha_sh_d  [NUM_CH];
  logic [NUM_CH-1:0]   mode_act_q, mode_act_d;
  logic [NUM_CH-1:0]   mode_sh_q, mode_sh_d;
  logic signed [34:0]  prod_q, prod_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic signed [16:0]  alpha_s;
  logic signed [17:0]  dif;
  logic signed [19:0]  y;
  logic signed [15:0]  y_sat;
  logic signed [15:0]  dith;

`ifdef RC_FILTER_SCHEDULER_DITHER_EN
  logic [7:0]          lfsr_q, lfsr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (audio_clk_en) begin
          state_d = ST_MUL;
          ch_d    = '0;
        end
      end
      ST_MUL: state_d = ST_WB;
      ST_WB: begin
        if (ch_q == LAST_CH) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = done_q;
    overrun = overrun_q;
  end

  always_comb begin
    out_d       = out_q;
    last_in_d   = last_in_q;
    snap_d      = snap_q;
    alpha_act_d = alpha_act_q;
    alpha_sh_d  = alpha_sh_q;
    mode_act_d  = mode_act_q;
    mode_sh_d   = mode_sh_q;
    prod_d      = prod_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    alpha_s     = '0;
    dif         = '0;
    y           = '0;
    y_sat       = '0;
`ifdef RC_FILTER_SCHEDULER_DITHER_EN
    lfsr_d      = lfsr_q;
    dith        = $signed({14'd0, lfsr_q[7:6]}) - 16'sd2;
`else
    dith        = '0;
`endif

    // Shadow write lands after the active copy below, so a write coincident
    // with the strobe only affects the following frame.
    if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      alpha_sh_d[cfg_ch] = cfg_alpha;
      mode_sh_d[cfg_ch]  = cfg_mode;
    end

    if (audio_clk_en && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (audio_clk_en) begin
          for (int k = 0; k < NUM_CH; k++) begin
            snap_d[k] = in_data[16*k +: 16];
          end
          alpha_act_d = alpha_sh_q;
          mode_act_d  = mode_sh_q;
`ifdef RC_FILTER_SCHEDULER_DITHER_EN
          lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        end
      end
      ST_MUL: begin
        alpha_s = $signed({1'b0, alpha_act_q[ch_q]});
        if (mode_act_q[ch_q]) begin
          dif = 18'(snap_q[ch_q]) - 18'(out_q[ch_q]);
        end else begin
          dif = 18'(out_q[ch_q]) + 18'(snap_q[ch_q]) - 18'(last_in_q[ch_q]);
        end
        prod_d = 35'(alpha_s) * 35'(dif);
      end
      ST_WB: begin
        y = 20'(prod_q >>> 16);
        if (mode_act_q[ch_q]) begin
          y = y + 20'(out_q[ch_q]);
        end
        if (y > 20'sd32767) begin
          y_sat = 16'sh7FFF;
        end else if (y < -20'sd32768) begin
          y_sat = 16'sh8000;
        end else begin
          y_sat = y[15:0];
        end
        out_d[ch_q] = y_sat;
        if (mode_act_q[ch_q]) begin
          last_in_d[ch_q] = snap_q[ch_q];
        end else begin
          last_in_d[ch_q] = snap_q[ch_q] + dith;
        end
        done_d = (ch_q == LAST_CH);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        out_q[k]       <= '0;
        last_in_q[k]   <= '0;
        snap_q[k]      <= '0;
        alpha_act_q[k] <= ALPHA_DEFAULT;
        alpha_sh_q[k]  <= ALPHA_DEFAULT;
      end
      mode_act_q <= '0;
      mode_sh_q  <= '0;
      prod_q     <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      last_in_q   <= last_in_d;
      snap_q      <= snap_d;
      alpha_act_q <= alpha_act_d;
      alpha_sh_q  <= alpha_sh_d;
      mode_act_q  <= mode_act_d;
      mode_sh_q   <= mode_sh_d;
      prod_q      <= prod_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef RC_FILTER_SCHEDULER_DITHER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign out_data[16*k +: 16] = out_q[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_rc_filter_scheduler.sv
`default_nettype none
// Testbench for rc_filter_scheduler: directed and random frames against a
// per-frame arithmetic model of the RC filter equations.
module tb_rc_filter_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           audio_clk_en;
  logic [N*16-1:0] in_data;
  logic [N*16-1:0] out_data;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [15:0]    cfg_alpha;
  logic           cfg_mode;
  logic           busy;
  logic           done;
  logic           overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int m_in[N];
  int m_out[N];
  int m_old[N];
  int m_last[N];
  int m_alpha_act[N];
  int m_alpha_sh[N];
  bit m_mode_act[N];
  bit m_mode_sh[N];
  bit m_ovr;

  always #5 clk = ~clk;

  rc_filter_scheduler #(.NUM_CH(N), .ALPHA_DEFAULT(16'hF000)) dut (
    .clk         (clk),
    .reset       (reset),
    .audio_clk_en(audio_clk_en),
    .in_data     (in_data),
    .out_data    (out_data),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_alpha   (cfg_alpha),
    .cfg_mode    (cfg_mode),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_in();
    for (int k = 0; k < N; k++) in_data[16*k +: 16] = 16'(m_in[k]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_out[k] = 0; m_last[k] = 0;
      m_alpha_act[k] = 'hF000; m_alpha_sh[k] = 'hF000;
      m_mode_act[k] = 1'b0; m_mode_sh[k] = 1'b0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; audio_clk_en = 1'b0; cfg_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_cfg(input int c, input int a, input bit m);
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_alpha = 16'(a); cfg_mode = m;
    m_alpha_sh[c] = a; m_mode_sh[c] = m;
  endtask

  task automatic cfg(input int c, input int a, input bit m);
    drive_cfg(c, a, m);
    tick();
    cfg_we = 1'b0;
  endtask

  // One whole frame of the filter, evaluated from the equations directly.
  task automatic model_frame();
    longint x, o, a, y;
    m_old = m_out;
    m_alpha_act = m_alpha_sh;
    m_mode_act  = m_mode_sh;
    for (int k = 0; k < N; k++) begin
      x = m_in[k]; o = m_out[k]; a = m_alpha_act[k];
      if (!m_mode_act[k]) y = (a * (o + x - m_last[k])) >>> 16;
      else                y = o + ((a * (x - o)) >>> 16);
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      m_out[k]  = int'(y);
      m_last[k] = int'(x);
    end
  endtask

  // ovr_at / cfg_at: edge offset from the strobe edge E0 (-1 = none).
  task automatic run_frame(input int ovr_at, input int cfg_at, input int cc, input int ca, input bit cm);
    logic [63:0] e;
    audio_clk_en = 1'b1;
    model_frame();
    if (cfg_at == 0) drive_cfg(cc, ca, cm);
    for (int c = 0; c <= 2*N + 1; c++) begin
      tick();
      audio_clk_en = 1'b0;
      cfg_we = 1'b0;
      if (c == 0) in_data = {$urandom, $urandom};
      if (ovr_at >= 0 && c >= ovr_at) m_ovr = 1'b1;
      for (int k = 0; k < N; k++)
        e[16*k +: 16] = (c >= 2*k + 2) ? 16'(m_out[k]) : 16'(m_old[k]);
      chk($sformatf("busy@E0+%0d", c), 64'(busy), 64'(c < 2*N));
      chk($sformatf("done@E0+%0d", c), 64'(done), 64'(c == 2*N));
      chk($sformatf("overrun@E0+%0d", c), 64'(overrun), 64'(m_ovr));
      chk($sformatf("out_data@E0+%0d", c), out_data, e);
      if (ovr_at == c + 1) audio_clk_en = 1'b1;
      if (cfg_at == c + 1) drive_cfg(cc, ca, cm);
    end
    apply_in();
  endtask

  initial begin
    reset = 1'b1; audio_clk_en = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_alpha = '0; cfg_mode = 1'b0; in_data = '0;
    for (int k = 0; k < N; k++) m_in[k] = 0;
    do_reset();
    chk("reset_out", out_data, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);

    cfg(0, 'h8000, 1'b0);
    cfg(1, 'h4000, 1'b1);
    cfg(2, 'h0000, 1'b0);
    m_in[0] = 1000; m_in[1] = 4000; m_in[2] = -32768; m_in[3] = 0;
    apply_in();
    run_frame(-1, -1, 0, 0, 1'b0);
    chk("hp_f1", 64'(out_data[15:0]), 64'(16'd500));
    chk("lp_f1", 64'(out_data[31:16]), 64'(16'd1000));
    chk("ch2_settle", 64'(out_data[47:32]), 64'd0);
    run_frame(-1, -1, 0, 0, 1'b0);
    chk("hp_f2", 64'(out_data[15:0]), 64'(16'd250));
    chk("lp_f2", 64'(out_data[31:16]), 64'(16'd1750));
    run_frame(-1, -1, 0, 0, 1'b0);
    chk("hp_f3", 64'(out_data[15:0]), 64'(16'd125));
    chk("lp_f3", 64'(out_data[31:16]), 64'(16'd2312));

    cfg(2, 'hFFFF, 1'b0);
    m_in[2] = 32767; apply_in();
    run_frame(-1, -1, 0, 0, 1'b0);
    chk("sat_pos", 64'(out_data[47:32]), 64'(16'h7FFF));
    cfg(2, 'h0000, 1'b0);
    run_frame(-1, -1, 0, 0, 1'b0);
    cfg(2, 'hFFFF, 1'b0);
    m_in[2] = -32768; apply_in();
    run_frame(-1, -1, 0, 0, 1'b0);
    chk("sat_neg", 64'(out_data[47:32]), 64'(16'h8000));

    run_frame(-1, 3, 0, 'h2000, 1'b0);
    run_frame(-1, -1, 0, 0, 1'b0);
    run_frame(-1, 0, 1, 'h1000, 1'b1);
    run_frame(-1, -1, 0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1) == 1)
        cfg(int'($urandom_range(N - 1)), int'($urandom_range(65535)), 1'($urandom_range(1)));
      for (int k = 0; k < N; k++) m_in[k] = int'($urandom_range(65535)) - 32768;
      apply_in();
      run_frame(-1, (i % 3 == 0) ? -1 : int'($urandom_range(2*N)),
                int'($urandom_range(N - 1)), int'($urandom_range(65535)), 1'($urandom_range(1)));
    end

    run_frame(4, -1, 0, 0, 1'b0);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    do_reset();
    chk("overrun_cleared", 64'(overrun), 64'd0);
    run_frame(2*N, -1, 0, 0, 1'b0);
    tick();
    chk("no_second_frame", 64'(busy), 64'd0);

    audio_clk_en = 1'b1;
    tick();
    audio_clk_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midreset_out", out_data, 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_overrun", 64'(overrun), 64'd0);
    tick();
    chk("midreset_idle", 64'(busy), 64'd0);
    for (int k = 0; k < N; k++) m_in[k] = int'($urandom_range(65535)) - 32768;
    apply_in();
    run_frame(-1, -1, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc_filter_scheduler.md
Name: rc_filter_scheduler

Overview:
- Time-multiplexed controller for first-order RC filter channels; one shared multiplier serves NUM_CH channels.
- Each channel is configured as high-pass or low-pass with its own smoothing coefficient.
- On every audio sample strobe, the block snapshots all channel inputs and steps through the channels in order.
- Sits between the per-voice discrete sound sources and the audio mixer, replacing per-channel filter instances.

Parameters:
- NUM_CH, 4, number of filter channels (2..16); CHW = max(1, clog2(NUM_CH)).
- ALPHA_DEFAULT, 16'hF000, reset coefficient of every channel, unsigned Q0.16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- audio_clk_en  in  1  one-cycle sample strobe.
- in_data  in  NUM_CH*16  signed samples; channel k occupies bits [16k+15:16k].
- out_data  out  NUM_CH*16  signed filtered samples, same packing.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  CHW  target channel of the configuration write.
- cfg_alpha  in  16  coefficient, unsigned Q0.16.
- cfg_mode  in  1  0 = high-pass, 1 = low-pass.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- overrun  out  1  sticky; strobe arrived while busy.

Behaviour:
- Reset (synchronous, highest priority, valid in any state, including mid-frame):
  - out_data = 0; per-channel last_in = 0.
  - busy = 0, done = 0, overrun = 0; state = IDLE.
  - All active and shadow alpha = ALPHA_DEFAULT; all mode = 0.
  - Any partial frame is discarded.
- States:
  - IDLE: on audio_clk_en, snapshot in_data, copy shadow config into active config, ch = 0, go to MUL.
  - MUL: compute the channel term and register the product; go to WB.
  - WB: write the saturated result to out_data[ch]. If ch == NUM_CH-1, go to IDLE and pulse done; else ch++, go to MUL.
- Timing: strobe sampled at edge E0.
  - busy = 1 after E0.
  - out_data channel k updates at edge E0+2k+2.
  - Last WB is at edge E0+2*NUM_CH. At that edge busy falls and done rises for exactly one cycle.
  - Frame length is 2*NUM_CH+1 cycles from strobe to done.
  - Channels not yet written hold their previous-frame value.
- High-pass (mode 0):
  - d = out + x - last_in, 18-bit signed.
  - p = alpha * d, where alpha is zero-extended to 17 bits signed.
  - y = p >>> 16, arithmetic shift (floor).
  - last_in <= x at WB.
- Low-pass (mode 1):
  - d = x - out, 17-bit signed.
  - y = out + ((alpha * d) >>> 16).
  - last_in is still updated to x.
- Saturation: y is clamped to [-32768, 32767] before it is written.
- x is always the snapshotted input, never live in_data.
- Configuration:
  - cfg_we writes shadow alpha/mode for cfg_ch in any state.
  - Shadow config reaches active config only at the IDLE→MUL transition, so no frame ever uses mixed coefficients.
  - cfg_ch >= NUM_CH: the write is ignored.
  - cfg_we in the same cycle as a strobe: the write misses the current frame and applies to the next one.
- Overrun:
  - audio_clk_en while busy (including the WB edge of the final channel) is dropped and sets overrun.
  - overrun clears only on reset.
  - The current frame completes unaffected.

Optional Feature:
- Macro: RC_FILTER_SCHEDULER_DITHER_EN.
- When defined:
  - An 8-bit LFSR advances once per frame, at the strobe.
  - The value stored to last_in in high-pass mode is x + ((lfsr >> 6) - 2), a range of -2..+1 LSB, which aids decay to 0.
  - Low-pass mode is unaffected.
  - The LFSR resets to 8'h01.
- When undefined: last_in = x exactly, no LFSR is instantiated, and the output is bit-exact deterministic.
- The Test Plan values assume the macro is undefined.

Test Plan:
- Reset, then NUM_CH=4, ch0 mode 0, alpha=16'h8000, in0 stepped 0→1000 before the first strobe → out0 = 500 after frame 1, 250 after frame 2, 125 after frame 3.
- ch1 mode 1, alpha=16'h4000, in1=4000 held → out1 = 1000, then 1750, then 2312.
- Single strobe at edge E0 → busy high during cycles E0+1..E0+8, done high for exactly one cycle after E0+8, out3 changes at E0+8 only.
- ch2 mode 0, alpha=16'hFFFF, out2 settled at 0 with in2=-32768, then in2=32767 → d=65535, result clamps to 32767; reversing the step clamps to -32768.
- Strobe at E0+4 → overrun=1, frame still ends at E0+8, no second frame starts.
- cfg_we to ch0 during busy → current frame uses the old alpha, next frame uses the new one.
- Reset asserted at E0+3 → next cycle all outputs 0 and state IDLE; a following strobe runs a normal frame.
